// File: rtl/traffic_phase_timer.sv
// Phase-duration timer for the highway/farm light FSM: 1 s prescaler, per-phase second count, level expiry flags.
// Optional macro TRAFFIC_TIMER_COUNTDOWN_EN adds the sec_left countdown output.
module traffic_phase_timer #(
  parameter int CLK_HZ = 50_000_000,
  parameter int RED_S  = 10,
  parameter int YEL_S  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RED_count_en,
  input  logic       YELLOW_count_en1,
  input  logic       YELLOW_count_en2,
  output logic       delay10s,
  output logic       delay3s1,
  output logic       delay3s2,
  output logic       tick_1s,
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
  output logic       conflict,
  output logic [3:0] sec_left
`else
  output logic       conflict
`endif
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(CLK_HZ - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {SEL_RED, SEL_Y1, SEL_Y2} sel_t;

  state_t        state;
  sel_t          sel;
  logic [PW-1:0] presc;
  logic [3:0]    sec;
  logic [3:0]    sec_inc;
  sel_t          active;
  logic          any_en;
  logic          multi_en;

  function automatic logic [3:0] dur_of(input sel_t s);
    return (s == SEL_RED) ? 4'(RED_S) : 4'(YEL_S);
  endfunction

  // Fixed priority: RED > Y1 > Y2.
  always_comb begin
    active = SEL_RED;
    if (RED_count_en)
      active = SEL_RED;
    else if (YELLOW_count_en1)
      active = SEL_Y1;
    else if (YELLOW_count_en2)
      active = SEL_Y2;
  end

  assign any_en   = RED_count_en | YELLOW_count_en1 | YELLOW_count_en2;
  assign multi_en = (RED_count_en & YELLOW_count_en1) | (RED_count_en & YELLOW_count_en2) |
                    (YELLOW_count_en1 & YELLOW_count_en2);
  assign sec_inc  = sec + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= SEL_RED;
      presc    <= '0;
      sec      <= '0;
      delay10s <= 1'b0;
      delay3s1 <= 1'b0;
      delay3s2 <= 1'b0;
      tick_1s  <= 1'b0;
      conflict <= 1'b0;
    end else begin
      if (multi_en)
        conflict <= 1'b1;
      case (state)
        IDLE: begin
          tick_1s <= 1'b0;
          if (any_en) begin
            state <= RUN;
            sel   <= active;
            presc <= '0;
            sec   <= '0;
          end
        end
        RUN, DONE: begin
          if (!any_en) begin
            state    <= IDLE;
            presc    <= '0;
            sec      <= '0;
            tick_1s  <= 1'b0;
            delay10s <= 1'b0;
            delay3s1 <= 1'b0;
            delay3s2 <= 1'b0;
          end else if (active != sel) begin
            // Source switched without a low gap: time the new phase from scratch.
            state    <= RUN;
            sel      <= active;
            presc    <= '0;
            sec      <= '0;
            tick_1s  <= 1'b0;
            delay10s <= 1'b0;
            delay3s1 <= 1'b0;
            delay3s2 <= 1'b0;
          end else if (state == RUN) begin
            if (presc == PRESC_LAST) begin
              presc   <= '0;
              sec     <= sec_inc;
              tick_1s <= 1'b0;
              if (sec_inc == dur_of(sel)) begin
                state    <= DONE;
                delay10s <= (sel == SEL_RED);
                delay3s1 <= (sel == SEL_Y1);
                delay3s2 <= (sel == SEL_Y2);
              end
            end else begin
              presc   <= presc + 1'b1;
              // Registered tick lands in the cycle where presc sits at its terminal count.
              tick_1s <= (presc == PRESC_PRE);
            end
          end
        end
        default: begin
          state   <= IDLE;
          tick_1s <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
  assign sec_left = (state == RUN) ? (dur_of(sel) - sec) : 4'd0;
`endif

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: directed scenarios plus random enable patterns against an elapsed-cycle model.
module tb_traffic_phase_timer;
  localparam int HZ    = 4;
  localparam int RED_S = 10;
  localparam int YEL_S = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic RED_count_en = 1'b0;
  logic YELLOW_count_en1 = 1'b0;
  logic YELLOW_count_en2 = 1'b0;
  logic delay10s, delay3s1, delay3s2, tick_1s, conflict;
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
  logic [3:0] sec_left;
`endif

  int checks = 0;
  int failures = 0;

  // Model state: which source is being timed (-1 none) and cycles since it started.
  int src = -1;
  int elapsed = 0;
  bit m_conf = 1'b0;

  always #5 clk = ~clk;

  traffic_phase_timer #(.CLK_HZ(HZ), .RED_S(RED_S), .YEL_S(YEL_S)) dut (
    .clk(clk),
    .rst(rst),
    .RED_count_en(RED_count_en),
    .YELLOW_count_en1(YELLOW_count_en1),
    .YELLOW_count_en2(YELLOW_count_en2),
    .delay10s(delay10s),
    .delay3s1(delay3s1),
    .delay3s2(delay3s2),
    .tick_1s(tick_1s),
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
    .conflict(conflict),
    .sec_left(sec_left)
`else
    .conflict(conflict)
`endif
  );

  function automatic int dur(input int s);
    return (s == 0) ? RED_S : YEL_S;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit [2:0] en);
    int a;
    if (r) begin
      src = -1; elapsed = 0; m_conf = 1'b0;
    end else begin
      if ($countones(en) >= 2) m_conf = 1'b1;
      a = en[2] ? 0 : (en[1] ? 1 : (en[0] ? 2 : -1));
      if (a < 0) begin
        src = -1; elapsed = 0;
      end else if (a != src) begin
        src = a; elapsed = 0;
      end else if (elapsed < 1000) begin
        elapsed++;
      end
    end
  endtask

  task automatic check_all();
    int  lim;
    bit  busy;
    bit  timing;
    lim    = (src >= 0) ? dur(src) * HZ : 0;
    busy   = (src >= 0);
    timing = busy && (elapsed < lim);
    check("delay10s", {3'b0, delay10s}, {3'b0, busy && src == 0 && elapsed >= lim});
    check("delay3s1", {3'b0, delay3s1}, {3'b0, busy && src == 1 && elapsed >= lim});
    check("delay3s2", {3'b0, delay3s2}, {3'b0, busy && src == 2 && elapsed >= lim});
    check("tick_1s",  {3'b0, tick_1s},  {3'b0, timing && ((elapsed + 1) % HZ == 0)});
    check("conflict", {3'b0, conflict}, {3'b0, m_conf});
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
    check("sec_left", sec_left, timing ? 4'(dur(src) - elapsed / HZ) : 4'd0);
`endif
  endtask

  // en = {RED_count_en, YELLOW_count_en1, YELLOW_count_en2}
  task automatic step(input bit r, input bit [2:0] en);
    rst = r;
    RED_count_en = en[2];
    YELLOW_count_en1 = en[1];
    YELLOW_count_en2 = en[0];
    @(posedge clk);
    model_update(r, en);
    #1;
    check_all();
  endtask

  task automatic run(input string name, input bit r, input bit [2:0] en, input int n);
    $display("seg %-10s rst=%0b en=%03b cycles=%0d", name, r, en, n);
    for (int i = 0; i < n; i++) step(r, en);
  endtask

  initial begin
    run("reset", 1'b1, 3'b111, 3);
    run("post_rst", 1'b0, 3'b111, 1);
    run("clr", 1'b1, 3'b000, 1);
    run("yellow1", 1'b0, 3'b010, 16);
    run("drop", 1'b0, 3'b000, 2);
    run("red", 1'b0, 3'b100, 44);
    run("drop", 1'b0, 3'b000, 2);
    run("abort_a", 1'b0, 3'b100, 20);
    run("gap", 1'b0, 3'b000, 5);
    run("abort_b", 1'b0, 3'b100, 45);
    run("drop", 1'b0, 3'b000, 1);
    run("conflict", 1'b0, 3'b101, 1);
    run("conf_hold", 1'b0, 3'b100, 42);
    run("conf_clr", 1'b1, 3'b000, 1);
    run("mid_a", 1'b0, 3'b100, 30);
    run("mid_rst", 1'b1, 3'b100, 1);
    run("mid_b", 1'b0, 3'b100, 44);
    run("yellow2", 1'b0, 3'b001, 14);
    run("switch", 1'b0, 3'b011, 15);
    for (int s = 0; s < 40; s++) begin
      bit [2:0] en;
      en = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) run("rand_rst", 1'b1, en, 1);
      run("random", 1'b0, en, $urandom_range(1, 50));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
